// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: NUM_CH outputs share one period counter. Period, duty and
// mode are staged in shadow registers and only switch over at a period boundary.
module pwm_multi #(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 11,
  parameter int DEFAULT_PERIOD = 1200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    center_in,
  input  logic [NUM_CH-1:0]       invert,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    update_pending
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] ZERO  = '0;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  logic [CNT_W-1:0]        count, count_nxt;
  dir_t                    dir, dir_nxt;
  logic                    boundary;
  logic [CNT_W-1:0]        period_a, period_s, period_clamped;
  logic [NUM_CH*CNT_W-1:0] duty_a, duty_s;
  logic                    center_a, center_s;
  logic [NUM_CH-1:0]       raw;

  assign period_clamped = (period_in < TWO) ? TWO : period_in;

  // Counter sequencing; boundary marks the last cycle of the current period.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    boundary  = 1'b0;
    if (center_a) begin
      if (dir == DIR_UP) begin
        if (count >= period_a - ONE) dir_nxt = DIR_DOWN;
        else                         count_nxt = count + ONE;
      end else if (count == ZERO) begin
        boundary = 1'b1;
        dir_nxt  = DIR_UP;
      end else begin
        count_nxt = count - ONE;
      end
    end else begin
      dir_nxt = DIR_UP;
      if (count >= period_a - ONE) begin
        boundary  = 1'b1;
        count_nxt = ZERO;
      end else begin
        count_nxt = count + ONE;
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++)
      raw[i] = (count < duty_a[i*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= ZERO;
      dir            <= DIR_UP;
      period_a       <= DEF_P;
      period_s       <= DEF_P;
      duty_a         <= '0;
      duty_s         <= '0;
      center_a       <= 1'b0;
      center_s       <= 1'b0;
      pwm_out        <= '0;
      period_start   <= 1'b0;
      update_pending <= 1'b0;
    end else if (!enable) begin
      // Idle: counter parked, active follows shadow so re-enable starts with fresh values.
      count          <= ZERO;
      dir            <= DIR_UP;
      pwm_out        <= invert;
      period_start   <= 1'b0;
      update_pending <= 1'b0;
      if (load) begin
        period_s <= period_clamped;
        duty_s   <= duty_in;
        center_s <= center_in;
        period_a <= period_clamped;
        duty_a   <= duty_in;
        center_a <= center_in;
      end else begin
        period_a <= period_s;
        duty_a   <= duty_s;
        center_a <= center_s;
      end
    end else begin
      count        <= count_nxt;
      dir          <= dir_nxt;
      pwm_out      <= raw ^ invert;
      period_start <= (count == ZERO) && (dir == DIR_UP);
      if (load) begin
        period_s <= period_clamped;
        duty_s   <= duty_in;
        center_s <= center_in;
      end
      // A load on the boundary cycle bypasses the shadow and governs the next period directly.
      if (boundary && (update_pending || load)) begin
        period_a       <= load ? period_clamped : period_s;
        duty_a         <= load ? duty_in : duty_s;
        center_a       <= load ? center_in : center_s;
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi: reset, edge/center modes, shadow loads, disable/invert,
// period clamping and mid-period reset.
module tb_pwm_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 11;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    load;
  logic [CNT_W-1:0]        period_in;
  logic [NUM_CH*CNT_W-1:0] duty_in;
  logic                    center_in;
  logic [NUM_CH-1:0]       invert;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_start;
  logic                    update_pending;

  int checks = 0;
  int errors = 0;

  pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(1200)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .period_in(period_in),
    .duty_in(duty_in), .center_in(center_in), .invert(invert), .pwm_out(pwm_out),
    .period_start(period_start), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL wait_ps: period_start not seen within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    int n;
    bit nonzero;
    rst = 1'b1; enable = 1'b1; load = 1'b0; period_in = '0; duty_in = '0;
    center_in = 1'b0; invert = '0;
    step(); step();
    checks++;
    if ({pwm_out, period_start, update_pending} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {pwm_out, period_start, update_pending});
    end
    rst = 1'b0;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_ps: got %b expected 1", period_start);
    end
    nonzero = 1'b0;
    n = 0;
    for (int i = 1; i <= 1300; i++) begin
      step();
      if (pwm_out !== 3'b000 || update_pending !== 1'b0) nonzero = 1'b1;
      if (period_start) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("[TB] FAIL reset_period: got %0d expected 1200", n);
    end
    checks++;
    if (nonzero) begin
      errors++;
      $display("[TB] FAIL reset_idle_outputs: got nonzero pwm/pending expected all 0");
    end
  endtask

  task automatic test_edge();
    logic [NUM_CH-1:0] exp;
    step(); step(); step(); step(); step();
    period_in = 11'd10; duty_in = {11'd10, 11'd0, 11'd3}; center_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (update_pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_pending_set: got %b expected 1", update_pending);
    end
    wait_ps(1300);
    checks++;
    if (update_pending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_pending_clear: got %b expected 0", update_pending);
    end
    for (int t = 0; t < 20; t++) begin
      exp = {1'b1, 1'b0, ((t % 10) < 3)};
      checks++;
      if (pwm_out !== exp) begin
        errors++;
        $display("[TB] FAIL edge_pwm t=%0d: got %b expected %b", t, pwm_out, exp);
      end
      checks++;
      if (period_start !== ((t % 10) == 0)) begin
        errors++;
        $display("[TB] FAIL edge_ps t=%0d: got %b expected %b", t, period_start, (t % 10) == 0);
      end
      step();
    end
  endtask

  task automatic test_center();
    logic [NUM_CH-1:0] exp;
    wait_ps(20);
    step(); step(); step();
    period_in = 11'd10; duty_in = {11'd10, 11'd0, 11'd3}; center_in = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    wait_ps(20);
    for (int t = 0; t < 40; t++) begin
      exp = {1'b1, 1'b0, ((t % 20) < 3) || ((t % 20) >= 17)};
      checks++;
      if (pwm_out !== exp) begin
        errors++;
        $display("[TB] FAIL center_pwm t=%0d: got %b expected %b", t, pwm_out, exp);
      end
      checks++;
      if (period_start !== ((t % 20) == 0)) begin
        errors++;
        $display("[TB] FAIL center_ps t=%0d: got %b expected %b", t, period_start, (t % 20) == 0);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] exp;
    step(); step();
    period_in = 11'd10; duty_in = {11'd10, 11'd0, 11'd5}; center_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    duty_in = {11'd10, 11'd0, 11'd7}; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (update_pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_pending_set: got %b expected 1", update_pending);
    end
    wait_ps(30);
    for (int t = 0; t < 10; t++) begin
      exp = {1'b1, 1'b0, (t < 7)};
      checks++;
      if (pwm_out !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_pwm t=%0d: got %b expected %b", t, pwm_out, exp);
      end
      checks++;
      if (update_pending !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_pending_low t=%0d: got %b expected 0", t, update_pending);
      end
      load = (t == 8);
      if (t == 8) begin
        period_in = 11'd6; duty_in = {11'd10, 11'd0, 11'd2};
      end
      step();
    end
    load = 1'b0;
    for (int u = 0; u < 12; u++) begin
      exp = {1'b1, 1'b0, ((u % 6) < 2)};
      checks++;
      if (pwm_out !== exp) begin
        errors++;
        $display("[TB] FAIL boundary_load_pwm u=%0d: got %b expected %b", u, pwm_out, exp);
      end
      checks++;
      if (period_start !== ((u % 6) == 0) || update_pending !== 1'b0) begin
        errors++;
        $display("[TB] FAIL boundary_load_ps u=%0d: got ps=%b pend=%b expected ps=%b pend=0",
                 u, period_start, update_pending, (u % 6) == 0);
      end
      step();
    end
  endtask

  task automatic test_disable();
    logic [NUM_CH-1:0] exp;
    enable = 1'b0; invert = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pwm_out !== 3'b101 || period_start !== 1'b0) begin
        errors++;
        $display("[TB] FAIL disable_idle i=%0d: got pwm=%b ps=%b expected pwm=101 ps=0",
                 i, pwm_out, period_start);
      end
    end
    period_in = 11'd8; duty_in = {11'd0, 11'd0, 11'd4}; center_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (update_pending !== 1'b0 || pwm_out !== 3'b101) begin
      errors++;
      $display("[TB] FAIL disable_load: got pend=%b pwm=%b expected pend=0 pwm=101",
               update_pending, pwm_out);
    end
    step();
    enable = 1'b1;
    step();
    for (int u = 0; u < 16; u++) begin
      exp = {1'b0, 1'b0, ((u % 8) < 4)} ^ 3'b101;
      checks++;
      if (pwm_out !== exp) begin
        errors++;
        $display("[TB] FAIL reenable_pwm u=%0d: got %b expected %b", u, pwm_out, exp);
      end
      checks++;
      if (period_start !== ((u % 8) == 0)) begin
        errors++;
        $display("[TB] FAIL reenable_ps u=%0d: got %b expected %b", u, period_start, (u % 8) == 0);
      end
      step();
    end
  endtask

  task automatic test_clamp();
    logic [NUM_CH-1:0] exp;
    invert = 3'b000;
    step();
    period_in = 11'd0; duty_in = {11'd0, 11'd0, 11'd1}; center_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    wait_ps(20);
    for (int t = 0; t < 6; t++) begin
      exp = {1'b0, 1'b0, ((t % 2) == 0)};
      checks++;
      if (pwm_out !== exp || period_start !== ((t % 2) == 0)) begin
        errors++;
        $display("[TB] FAIL clamp t=%0d: got pwm=%b ps=%b expected pwm=%b ps=%b",
                 t, pwm_out, period_start, exp, (t % 2) == 0);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit nonzero;
    step();
    period_in = 11'd20; duty_in = {11'd5, 11'd5, 11'd5}; center_in = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (update_pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pending_set: got %b expected 1", update_pending);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({pwm_out, period_start, update_pending} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got %b expected 00000", {pwm_out, period_start, update_pending});
    end
    step();
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_first_ps: got %b expected 1", period_start);
    end
    nonzero = 1'b0;
    n = 0;
    for (int i = 1; i <= 1300; i++) begin
      step();
      if (pwm_out !== 3'b000 || update_pending !== 1'b0) nonzero = 1'b1;
      if (period_start) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("[TB] FAIL midrst_period: got %0d expected 1200", n);
    end
    checks++;
    if (nonzero) begin
      errors++;
      $display("[TB] FAIL midrst_duty_zero: got nonzero pwm/pending expected all 0");
    end
  endtask

  initial begin
    $display("[TB] starting pwm_multi tests");
    test_reset();
    test_edge();
    test_center();
    test_back_to_back();
    test_disable();
    test_clamp();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
